data_memory_ctrl: RTL
=====================

Name: data_memory_ctrl

Overview:
Parametrised byte-addressed data memory with a request/response handshake and configurable wait states. It is the multi-cycle successor to the single-cycle DataMemory. It supports byte, half and word loads and stores, with sign or zero extension on loads. Misaligned, illegal-size and out-of-range accesses are flagged with an error response. It sits in the MEM stage behind the pipeline's memory-stall logic.

Parameters:
DEPTH, 1024, number of 32-bit words (power of two not required)
ADDR_WIDTH, 32, width of the byte address
WAIT_STATES, 1, extra cycles spent in BUSY before the access commits (0..15)

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  reset, synchronous, active-low
Req  in  1  request valid
Ready  out  1  controller can accept a request (IDLE only)
Addr  in  ADDR_WIDTH  byte address
Write  in  1  1 = store, 0 = load
Size  in  2  00 byte, 01 half, 10 word, 11 illegal
Unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
WriteData  in  32  store data; the low byte or half is used for sub-word stores
RespValid  out  1  one-cycle response strobe
ReadData  out  32  extended load data; 0 on stores and errors
Err  out  1  error flag, valid with RespValid

Behaviour:
- Reset (Rst=0 at a rising edge): state IDLE, Ready=1, RespValid=0, ReadData=0, Err=0, wait counter=0. Memory array contents are not cleared.
- States:
  - IDLE: Ready=1. A request is accepted on an edge with Req=1. On acceptance, Addr/Write/Size/Unsigned/WriteData are captured, the counter is loaded with WAIT_STATES, and the state goes to BUSY.
  - BUSY: Ready=0; inputs are ignored.
    - If counter != 0: decrement the counter.
    - If counter == 0: perform the access on that edge (store commits, load data registered, Err registered) and go to RESP.
  - RESP: RespValid=1 for exactly one cycle, Ready=0. The next edge returns to IDLE. ReadData and Err hold their values until the next response.
- Latency: if the accept edge is E0, the access commits at E0+WAIT_STATES+1 and RespValid is high between E0+WAIT_STATES+1 and E0+WAIT_STATES+2. Back-to-back requests are therefore spaced WAIT_STATES+3 cycles apart.
- Req is level-sampled only in IDLE. A Req held high is taken as a new request on the first IDLE edge.
- Byte order is little-endian. Word index = Addr[ADDR_WIDTH-1:2]; the lane is selected by Addr[1:0].
  - Byte: lane Addr[1:0].
  - Half: Addr[1]=0 selects bits 15:0; Addr[1]=1 selects bits 31:16.
- Stores write only the addressed lanes; the other bytes of the word are preserved.
- Loads return the selected lane, extended to 32 bits. Sign extension copies bit 7 (byte) or bit 15 (half). A word load ignores Unsigned.
- Error conditions (any one):
  - Size=11.
  - Half access with Addr[0]=1.
  - Word access with Addr[1:0]!=00.
  - Word index >= DEPTH.
- On error: no memory write, ReadData=0, Err=1 with RespValid. The FSM timing is identical to a normal access.
- Reset asserted in BUSY before the commit edge: the access is aborted, no write occurs, no response is issued, and the block returns to IDLE. Reset asserted in RESP: the response is dropped and outputs are cleared.
- Reset and Req at the same edge: reset wins and the request is not accepted.

Test Plan:
- WAIT_STATES=1, word store 0xFFFFFFFF at Addr 0, then lb Addr 0 -> ReadData 0xFFFFFFFF, Err 0; lbu Addr 0 -> 0x000000FF; RespValid high exactly between edges E0+2 and E0+3.
- Word store 0x87654321 at Addr 4 -> lh Addr 6 = 0xFFFF8765; lhu Addr 4 = 0x00004321; lb Addr 7 = 0xFFFFFF87; lbu Addr 5 = 0x00000043.
- sb 0x123456AA at Addr 5, then lw Addr 4 -> 0x8765AA21. sh 0x0000BEEF at Addr 6, then lw Addr 4 -> 0xBEEFAA21.
- Error responses:
  - lh Addr 1 -> Err 1, ReadData 0.
  - sw Addr 2 -> Err 1, and a following lw Addr 0 is unchanged.
  - Size=11 -> Err 1.
  - DEPTH=64, lw Addr 0x100 -> Err 1.
- WAIT_STATES=3, sw 0xDEADBEEF at Addr 8, Rst=0 for one edge during BUSY with counter 2 -> no RespValid; lw Addr 8 returns the old contents; Ready=1 on the first edge after reset.
- Req held high continuously, WAIT_STATES=0 -> accepts exactly every 3 cycles; Ready low in BUSY/RESP; sweep WAIT_STATES over 0, 1, 15 and check latency matches.

Source files
------------

// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between the MEM stage (master) and data_memory_ctrl (slave).
interface data_memory_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req;
  logic                  ready;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  write;
  logic [1:0]            size;
  logic                  load_unsigned;
  logic [31:0]           write_data;
  logic                  resp_valid;
  logic [31:0]           read_data;
  logic                  err;

  modport master (
    output req, addr, write, size, load_unsigned, write_data,
    input  ready, resp_valid, read_data, err
  );

  modport slave (
    input  req, addr, write, size, load_unsigned, write_data,
    output ready, resp_valid, read_data, err
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// Byte-addressed little-endian data memory with a req/resp handshake and
// WAIT_STATES extra busy cycles; sub-word loads/stores and error responses.
module data_memory_ctrl #(
  parameter int DEPTH       = 1024,
  parameter int ADDR_WIDTH  = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  data_memory_ctrl_if.slave  bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-3:0] DEPTH_IDX = (ADDR_WIDTH-2)'(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [31:0]           wdata_q;

  // NOTE: the array has no reset; only the control state is reset.
  logic [31:0] mem [DEPTH];

  logic        commit;
  logic        acc_err;
  logic [31:0] rd_word;
  logic [31:0] shifted;
  logic [31:0] load_val;
  logic [31:0] store_word;
  logic [3:0]  be;

  assign commit  = (state == BUSY) && (cnt == 4'd0);
  assign rd_word = mem[addr_q[IDX_W+1:2]];
  assign shifted = rd_word >> {addr_q[1:0], 3'b000};
  assign acc_err = (size_q == 2'b11)
                || (size_q == 2'b01 && addr_q[0])
                || (size_q == 2'b10 && addr_q[1:0] != 2'b00)
                || (addr_q[ADDR_WIDTH-1:2] >= DEPTH_IDX);

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    load_val   = shifted;
    store_word = wdata_q;
    be         = 4'b0000;
    unique case (size_q)
      2'b00: begin
        load_val   = uns_q ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
        store_word = {4{wdata_q[7:0]}};
        be         = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        load_val   = uns_q ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        store_word = {2{wdata_q[15:0]}};
        be         = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // A reset on the commit edge aborts the store.
  always_ff @(posedge clk) begin
    if (rst_n && commit && write_q && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr_q[IDX_W+1:2]][8*i +: 8] <= store_word[8*i +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      addr_q         <= '0;
      write_q        <= 1'b0;
      size_q         <= 2'b00;
      uns_q          <= 1'b0;
      wdata_q        <= 32'd0;
      bus.ready      <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.read_data  <= 32'd0;
      bus.err        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req) begin
            addr_q    <= bus.addr;
            write_q   <= bus.write;
            size_q    <= bus.size;
            uns_q     <= bus.load_unsigned;
            wdata_q   <= bus.write_data;
            cnt       <= 4'(WAIT_STATES);
            bus.ready <= 1'b0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            bus.read_data  <= (acc_err || write_q) ? 32'd0 : load_val;
            bus.err        <= acc_err;
            bus.resp_valid <= 1'b1;
            state          <= RESP;
          end
        end
        RESP: begin
          bus.resp_valid <= 1'b0;
          bus.ready      <= 1'b1;
          state          <= IDLE;
        end
        default: begin
          bus.resp_valid <= 1'b0;
          bus.ready      <= 1'b1;
          state          <= IDLE;
        end
      endcase
    end
  end
endmodule
